spi_master_phy: RTL and testbench
=================================

// Module: spi_master_phy
// PURPOSE
//  SPI mode-0 master serializer: the PHY end of the spi_mosi/spi_begin/spi_busy/spi_wide/spi_cs bus driven by lcd_if.
//  Accepts one 8-bit or 32-bit word per begin, shifts it MSB-first on SCK and captures MISO in parallel.
//  Reports busy for the whole shift. Sits between lcd_if (or the SD-card controller) and the board SPI pins.
// PARAMETERS
//  CLK_DIV   1   SCK half-period in clk cycles (>=1); SCK = clk/(2*CLK_DIV)
// PORTS
//  clk         in   1   system clock, single clock domain
//  rst_n       in   1   asynchronous, active-low reset
//  spi_begin   in   1   start request; level, armed (see BEHAVIOUR)
//  spi_wide    in   1   1: 32-bit transfer, 0: 8-bit transfer (uses spi_mosi[7:0])
//  spi_mosi    in   32  word to transmit
//  spi_cs      in   1   chip-select request from client, active low
//  spi_miso    out  32  last received word; 8-bit transfer -> {24'h0, byte}
//  spi_busy    out  1   transfer in progress
//  sck_o       out  1   SPI clock pin, idle low
//  mosi_o      out  1   SPI data-out pin
//  miso_i      in   1   SPI data-in pin
//  cs_n_o      out  1   chip-select pin, registered copy of spi_cs
// BEHAVIOUR
//  Reset (async, rst_n=0): spi_busy=0, sck_o=0, mosi_o=0, cs_n_o=1, spi_miso=0, armed=1, state IDLE, counters 0.
//  cs_n_o <= spi_cs every cycle (1-cycle latency). The PHY never gates CS; the client owns framing.
//  Arming: begin is accepted only in IDLE with armed=1. Acceptance clears armed.
//    armed is set again on the first cycle spi_begin=0 is sampled. A begin held high across the end of a
//    transfer therefore never retriggers.
//  FSM states: IDLE, LOW (SCK low phase), HIGH (SCK high phase), DONE.
//   IDLE: on spi_begin & armed at edge T, latch shreg <= wide ? spi_mosi : {spi_mosi[7:0],24'h0},
//     nbits <= wide ? 32 : 8, rxreg <= 0. Goto LOW.
//     At T+1: spi_busy=1, mosi_o=first bit (MSB), sck_o=0.
//   LOW: hold CLK_DIV cycles. Then sck_o<=1, rxreg <= {rxreg[30:0], miso_i} (sample on the rising edge). Goto HIGH.
//   HIGH: hold CLK_DIV cycles. Then sck_o<=0 and decrement the bit count.
//     If bits remain: shift shreg left, mosi_o <= next bit (change on the falling edge), goto LOW.
//     Otherwise goto DONE.
//   DONE: one cycle. spi_miso <= wide ? rxreg : {24'h0, rxreg[7:0]}. Next edge: spi_busy=0, goto IDLE.
//  spi_busy is high for exactly 2*CLK_DIV*N + 1 cycles (N = 8 or 32). spi_miso is valid when spi_busy falls.
//  mosi_o holds its last bit after the transfer, until the next accept.
//  spi_mosi/spi_wide changes while busy are ignored (latched at accept). spi_begin while busy is ignored.
//  Bit counter is 6 bits. Half-period counter is $clog2(CLK_DIV+1) bits and wraps to 0 on each phase change.
//  Reset mid-transfer: immediate abort. SCK returns low asynchronously, no partial spi_miso update.
//  CLK_DIV=1: each phase lasts exactly one clk cycle, with no idle cycle between bits.
// STRUCTURE
//  lcd_spi_pkg (shared with lcd_if): FSM state localparams, SPI_W_NARROW=8, SPI_W_WIDE=32, bit-count width.
//  Sub-module spi_clk_div: free-running half-period counter with sync clear.
//    Emits a 1-cycle phase_tick every CLK_DIV cycles while enabled.
//  Top holds the FSM, shift/receive registers, arm flag and CS register.
// TESTING
//  1 narrow, CLK_DIV=1: mosi=32'hA5, wide=0, miso_i loopback to mosi_o.
//    -> 8 SCK pulses, mosi_o bits 1,0,1,0,0,1,0,1; busy 17 cycles; spi_miso=32'h000000A5.
//  2 wide, CLK_DIV=2: mosi=32'hDEADBEEF, miso_i driven by a slave model returning 32'h12345678.
//    -> 32 SCK pulses, each high 2 cycles; busy 129 cycles; spi_miso=32'h12345678.
//  3 lcd_if handshake: begin held 3 cycles after busy rises, then held again past the busy fall.
//    -> exactly one transfer; a second starts only after begin drops and rises.
//  4 reset mid-wide transfer (after 10 bits).
//    -> same cycle: sck_o=0, busy=0, cs_n_o=1, spi_miso unchanged (0); next begin runs a full clean transfer.
//  5 mosi/wide toggled while busy (wide=1 -> 0, mosi -> 0).
//    -> transmitted bits and length match the values latched at accept.
//  6 CS passthrough: spi_cs 1->0 at begin.
//    -> cs_n_o falls 1 cycle later, before the first SCK rise; cs_n_o=1 at idle after reset.

Source files
------------

// File: rtl/lcd_spi_pkg.sv
// Shared definitions for the lcd_if <-> SPI PHY bus: transfer widths,
// bit-counter width and the serializer state encoding.
package lcd_spi_pkg;

   localparam int SPI_W_NARROW = 8;
   localparam int SPI_W_WIDE   = 32;
   localparam int SPI_BITCNT_W = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOW,
      ST_HIGH,
      ST_DONE
   } spi_state_e;

   function automatic logic [SPI_BITCNT_W-1:0] spi_nbits(input logic wide);
      return wide ? SPI_BITCNT_W'(SPI_W_WIDE) : SPI_BITCNT_W'(SPI_W_NARROW);
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer for the SPI serializer: pulses phase_tick on the last
// cycle of every CLK_DIV-cycle window while enabled.
module spi_clk_div #(
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic phase_tick
);

   localparam int CW = $clog2(CLK_DIV + 1);

   logic [CW-1:0] cnt;

   assign phase_tick = enable && (cnt == CW'(CLK_DIV - 1));

   // Wrapping to zero on the tick makes every phase start from a clean count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || phase_tick) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/spi_master_phy.sv
// SPI mode-0 master serializer: shifts one 8- or 32-bit word MSB-first on SCK
// while capturing MISO, with an arm flag so a held begin fires only once.
module spi_master_phy
   import lcd_spi_pkg::*;
#(
   parameter int CLK_DIV = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        spi_begin,
   input  logic        spi_wide,
   input  logic [31:0] spi_mosi,
   input  logic        spi_cs,
   output logic [31:0] spi_miso,
   output logic        spi_busy,
   output logic        sck_o,
   output logic        mosi_o,
   input  logic        miso_i,
   output logic        cs_n_o
);

   spi_state_e state, state_nxt;

   logic [31:0]             shreg;
   logic [31:0]             rxreg;
   logic [SPI_BITCNT_W-1:0] bit_cnt;
   logic                    wide_q;
   logic                    armed;
   logic                    phase_tick;
   logic                    div_en;
   logic                    accept;
   logic                    rise;
   logic                    fall;
   logic                    done;

   spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (state == ST_IDLE),
      .enable     (div_en),
      .phase_tick (phase_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      rise      = 1'b0;
      fall      = 1'b0;
      done      = 1'b0;
      div_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (spi_begin && armed) begin
               accept    = 1'b1;
               state_nxt = ST_LOW;
            end
         end
         ST_LOW: begin
            div_en = 1'b1;
            if (phase_tick) begin
               rise      = 1'b1;
               state_nxt = ST_HIGH;
            end
         end
         ST_HIGH: begin
            div_en = 1'b1;
            if (phase_tick) begin
               fall      = 1'b1;
               state_nxt = (bit_cnt == SPI_BITCNT_W'(1)) ? ST_DONE : ST_LOW;
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Narrow words are left-aligned so the MSB is always shreg[31].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg    <= '0;
         rxreg    <= '0;
         bit_cnt  <= '0;
         wide_q   <= 1'b0;
         spi_busy <= 1'b0;
         sck_o    <= 1'b0;
         mosi_o   <= 1'b0;
         spi_miso <= '0;
      end else begin
         if (accept) begin
            shreg    <= spi_wide ? spi_mosi : {spi_mosi[7:0], 24'h0};
            bit_cnt  <= spi_nbits(spi_wide);
            rxreg    <= '0;
            wide_q   <= spi_wide;
            spi_busy <= 1'b1;
            sck_o    <= 1'b0;
            mosi_o   <= spi_wide ? spi_mosi[31] : spi_mosi[7];
         end
         if (rise) begin
            sck_o <= 1'b1;
            rxreg <= {rxreg[30:0], miso_i};
         end
         if (fall) begin
            sck_o   <= 1'b0;
            bit_cnt <= bit_cnt - SPI_BITCNT_W'(1);
            if (bit_cnt != SPI_BITCNT_W'(1)) begin
               shreg  <= {shreg[30:0], 1'b0};
               mosi_o <= shreg[30];
            end
         end
         if (done) begin
            spi_miso <= wide_q ? rxreg : {24'h0, rxreg[7:0]};
            spi_busy <= 1'b0;
         end
      end
   end

   // Re-arm only after begin is seen low, so a held request cannot retrigger.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed  <= 1'b1;
         cs_n_o <= 1'b1;
      end else begin
         cs_n_o <= spi_cs;
         if (accept) begin
            armed <= 1'b0;
         end else if (!spi_begin) begin
            armed <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_master_phy.sv
// Bench for spi_master_phy: two instances (CLK_DIV=1 and 2) driven in lockstep
// and checked every cycle against a transaction-level model of the SPI bus.
module tb_spi_master_phy;

   localparam int LANES    = 2;
   localparam int MAX_WAIT = 2000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        spi_begin, spi_wide, spi_cs, loopback;
   logic [31:0] spi_mosi, slave_word;

   logic [31:0] miso_w    [LANES];
   logic        busy      [LANES];
   logic        sck       [LANES];
   logic        mosi      [LANES];
   logic        cs_n      [LANES];
   logic        miso_in   [LANES];
   logic        slave_bit [LANES];

   int vectors = 0;
   int miscompares = 0;

   spi_master_phy #(.CLK_DIV(1)) u_dut_div1 (
      .clk(clk), .rst_n(rst_n), .spi_begin(spi_begin), .spi_wide(spi_wide),
      .spi_mosi(spi_mosi), .spi_cs(spi_cs), .spi_miso(miso_w[0]), .spi_busy(busy[0]),
      .sck_o(sck[0]), .mosi_o(mosi[0]), .miso_i(miso_in[0]), .cs_n_o(cs_n[0])
   );

   spi_master_phy #(.CLK_DIV(2)) u_dut_div2 (
      .clk(clk), .rst_n(rst_n), .spi_begin(spi_begin), .spi_wide(spi_wide),
      .spi_mosi(spi_mosi), .spi_cs(spi_cs), .spi_miso(miso_w[1]), .spi_busy(busy[1]),
      .sck_o(sck[1]), .mosi_o(mosi[1]), .miso_i(miso_in[1]), .cs_n_o(cs_n[1])
   );

   assign miso_in[0] = loopback ? mosi[0] : slave_bit[0];
   assign miso_in[1] = loopback ? mosi[1] : slave_bit[1];

   // Model: a transfer is a busy window of 2*D*N+1 cycles; cycle k maps to
   // bit (k-1)/(2D), with SCK high in the second half of each bit slot.
   bit          m_busy  [LANES];
   bit          m_armed [LANES];
   int          m_k     [LANES];
   int          m_n     [LANES];
   logic [31:0] m_tx    [LANES];
   logic [31:0] m_resp  [LANES];
   logic [31:0] m_miso  [LANES];
   logic        m_cs    [LANES];
   logic        m_idle_mosi [LANES];

   function automatic int lane_div(input int l);
      return l + 1;
   endfunction

   function automatic logic exp_sck(input int l);
      int d = lane_div(l);
      if (!m_busy[l] || m_k[l] > 2 * d * m_n[l]) return 1'b0;
      return ((m_k[l] - 1) % (2 * d)) >= d;
   endfunction

   function automatic logic exp_mosi(input int l);
      int d = lane_div(l);
      if (!m_busy[l]) return m_idle_mosi[l];
      if (m_k[l] > 2 * d * m_n[l]) return m_tx[l][0];
      return m_tx[l][m_n[l] - 1 - (m_k[l] - 1) / (2 * d)];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int l = 0; l < LANES; l++) begin
         if (!rst_n) begin
            m_busy[l] = 1'b0; m_armed[l] = 1'b1; m_k[l] = 0; m_n[l] = 8;
            m_tx[l] = '0; m_resp[l] = '0; m_miso[l] = '0; m_cs[l] = 1'b1;
            m_idle_mosi[l] = 1'b0;
         end else begin
            m_cs[l] = spi_cs;
            if (m_busy[l]) begin
               if (m_k[l] == 2 * lane_div(l) * m_n[l] + 1) begin
                  m_busy[l] = 1'b0;
                  m_miso[l] = (m_n[l] == 32) ? m_resp[l] : {24'h0, m_resp[l][7:0]};
                  m_idle_mosi[l] = m_tx[l][0];
               end else begin
                  m_k[l] = m_k[l] + 1;
               end
            end else if (spi_begin && m_armed[l]) begin
               m_busy[l]  = 1'b1;
               m_armed[l] = 1'b0;
               m_k[l]     = 1;
               m_n[l]     = spi_wide ? 32 : 8;
               m_tx[l]    = spi_wide ? spi_mosi : {24'h0, spi_mosi[7:0]};
               m_resp[l]  = loopback ? m_tx[l] : (spi_wide ? slave_word : {24'h0, slave_word[7:0]});
            end
            if (!spi_begin) m_armed[l] = 1'b1;
         end
      end
   end

   // Slave drives the current bit of its response for the whole bit slot.
   always @(negedge clk) begin
      for (int l = 0; l < LANES; l++) begin
         if (m_busy[l] && m_k[l] <= 2 * lane_div(l) * m_n[l])
            slave_bit[l] = m_resp[l][m_n[l] - 1 - (m_k[l] - 1) / (2 * lane_div(l))];
         else
            slave_bit[l] = 1'b0;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int l = 0; l < LANES; l++) begin
         checkOutput($sformatf("busy lane%0d", l), 32'(busy[l]), 32'(m_busy[l]));
         checkOutput($sformatf("sck lane%0d", l), 32'(sck[l]), 32'(exp_sck(l)));
         checkOutput($sformatf("mosi lane%0d", l), 32'(mosi[l]), 32'(exp_mosi(l)));
         checkOutput($sformatf("cs_n lane%0d", l), 32'(cs_n[l]), 32'(m_cs[l]));
         checkOutput($sformatf("spi_miso lane%0d", l), miso_w[l], m_miso[l]);
      end
   end

   // Observed per-transfer statistics, restarted whenever busy rises.
   int          busy_cyc   [LANES];
   int          sck_pulses [LANES];
   int          xfers      [LANES];
   logic [31:0] seen_tx    [LANES];
   logic        prev_busy  [LANES];
   logic        prev_sck   [LANES];

   initial for (int l = 0; l < LANES; l++) xfers[l] = 0;

   always @(negedge clk) begin
      for (int l = 0; l < LANES; l++) begin
         if (busy[l] === 1'b1 && prev_busy[l] === 1'b0) begin
            busy_cyc[l] = 0; sck_pulses[l] = 0; seen_tx[l] = '0; xfers[l]++;
         end
         if (busy[l] === 1'b1) busy_cyc[l]++;
         if (sck[l] === 1'b1 && prev_sck[l] === 1'b0) begin
            sck_pulses[l]++;
            seen_tx[l] = {seen_tx[l][30:0], mosi[l]};
         end
         prev_busy[l] = busy[l];
         prev_sck[l]  = sck[l];
      end
   end

   task automatic applyStimulus(input logic wide, input logic [31:0] word, input logic [31:0] resp,
                                input logic lb, input int hold);
      @(negedge clk);
      spi_wide = wide; spi_mosi = word; slave_word = resp; loopback = lb;
      spi_cs = 1'b0; spi_begin = 1'b1;
      repeat (hold) @(negedge clk);
      spi_begin = 1'b0;
   endtask

   task automatic waitIdle();
      int n = 0;
      while ((busy[0] !== 1'b0 || busy[1] !== 1'b0) && n < MAX_WAIT) begin
         @(negedge clk);
         n++;
      end
      checkOutput("idle after wait", 32'(busy[0] | busy[1]), 32'd0);
      @(negedge clk);
      spi_cs = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int x0, x1;
      logic [31:0] w, r;
      logic wd, lb;
      spi_begin = 1'b0; spi_wide = 1'b0; spi_mosi = '0; spi_cs = 1'b1;
      loopback = 1'b0; slave_word = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset cs_n", 32'(cs_n[0]), 32'd1);
      checkOutput("reset busy", 32'(busy[0]), 32'd0);
      checkOutput("reset sck", 32'(sck[1]), 32'd0);
      checkOutput("reset spi_miso", miso_w[1], 32'd0);
      #2 rst_n = 1'b1;

      $display("[TB] narrow loopback 0xA5");
      applyStimulus(1'b0, 32'h0000_00A5, 32'h0, 1'b1, 1);
      waitIdle();
      checkOutput("t1 busy cycles div1", busy_cyc[0], 32'd17);
      checkOutput("t1 sck pulses div1", sck_pulses[0], 32'd8);
      checkOutput("t1 mosi bits div1", seen_tx[0], 32'h0000_00A5);
      checkOutput("t1 spi_miso div1", miso_w[0], 32'h0000_00A5);
      checkOutput("t1 busy cycles div2", busy_cyc[1], 32'd33);

      $display("[TB] wide 0xDEADBEEF, slave 0x12345678");
      applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1);
      waitIdle();
      checkOutput("t2 busy cycles div2", busy_cyc[1], 32'd129);
      checkOutput("t2 sck pulses div2", sck_pulses[1], 32'd32);
      checkOutput("t2 mosi bits div2", seen_tx[1], 32'hDEAD_BEEF);
      checkOutput("t2 spi_miso div2", miso_w[1], 32'h1234_5678);
      checkOutput("t2 busy cycles div1", busy_cyc[0], 32'd65);

      $display("[TB] held begin fires once");
      x0 = xfers[0]; x1 = xfers[1];
      applyStimulus(1'b0, 32'h0000_005A, 32'h0000_00C3, 1'b0, 60);
      waitIdle();
      checkOutput("t3 xfers div1", xfers[0] - x0, 32'd1);
      checkOutput("t3 xfers div2", xfers[1] - x1, 32'd1);
      applyStimulus(1'b0, 32'h0000_0011, 32'h0000_0022, 1'b0, 3);
      waitIdle();
      checkOutput("t3 rearm xfers div1", xfers[0] - x0, 32'd2);

      $display("[TB] reset mid-transfer");
      applyStimulus(1'b1, 32'hF0F0_1234, 32'hAAAA_5555, 1'b0, 1);
      repeat (21) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t4 sck after reset", 32'(sck[0]), 32'd0);
      checkOutput("t4 busy after reset", 32'(busy[0]), 32'd0);
      checkOutput("t4 cs_n after reset", 32'(cs_n[0]), 32'd1);
      checkOutput("t4 spi_miso after reset", miso_w[0], 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      spi_cs = 1'b1;
      applyStimulus(1'b1, 32'h0BAD_F00D, 32'h8765_4321, 1'b0, 1);
      waitIdle();
      checkOutput("t4 clean spi_miso div1", miso_w[0], 32'h8765_4321);
      checkOutput("t4 clean spi_miso div2", miso_w[1], 32'h8765_4321);

      $display("[TB] inputs changed while busy");
      applyStimulus(1'b1, 32'hC3C3_0F0F, 32'h0F0F_C3C3, 1'b0, 1);
      repeat (3) @(negedge clk);
      spi_wide = 1'b0; spi_mosi = '0;
      waitIdle();
      checkOutput("t5 sck pulses div1", sck_pulses[0], 32'd32);
      checkOutput("t5 mosi bits div1", seen_tx[0], 32'hC3C3_0F0F);

      $display("[TB] chip-select passthrough");
      @(negedge clk);
      spi_cs = 1'b0; spi_begin = 1'b1; spi_wide = 1'b0; spi_mosi = 32'h3C;
      @(negedge clk);
      checkOutput("t6 cs_n low", 32'(cs_n[0]), 32'd0);
      checkOutput("t6 sck still low", 32'(sck[0]), 32'd0);
      spi_begin = 1'b0;
      waitIdle();

      $display("[TB] randomized transfers");
      for (int i = 0; i < 40; i++) begin
         wd = 1'($urandom_range(0, 1));
         lb = 1'($urandom_range(0, 1));
         w  = $urandom;
         r  = $urandom;
         applyStimulus(wd, w, r, lb, $urandom_range(1, 40));
         if ($urandom_range(0, 1) == 1) begin
            spi_mosi = $urandom;
            spi_wide = 1'($urandom_range(0, 1));
         end
         waitIdle();
         if (lb) r = w;
         if (!wd) r = {24'h0, r[7:0]};
         checkOutput($sformatf("rand%0d spi_miso div1", i), miso_w[0], r);
         checkOutput($sformatf("rand%0d spi_miso div2", i), miso_w[1], r);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
